// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, default widths and the buffered result record.
package alu_pkg;
  localparam int ALU_W     = 32;
  localparam int ALU_TAG_W = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic [ALU_W-1:0]     r;
    logic                 zero;
    logic                 carry;
    logic [ALU_TAG_W-1:0] tag;
  } alu_result_t;

  function automatic logic is_addsub(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction
endpackage

// File: rtl/alu_ovf_detect.sv
// Signed-overflow trap qualification with a one-cycle exception pulse
// and a sticky status bit.
module alu_ovf_detect
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_fire,
  input  logic       in_v,
  input  logic [2:0] in_aluop,
  input  logic       in_trap_en,
  input  logic       ovf_clr,
  output logic       trap,
  output logic       ovf_exc,
  output logic       ovf_sticky
);
  logic exc_q, exc_d;
  logic sticky_q, sticky_d;

  assign trap = in_fire & in_trap_en & in_v & is_addsub(in_aluop);

  always_comb begin
    exc_d    = trap;
    sticky_d = sticky_q;
    // A new trap outranks a clear in the same cycle.
    if (trap)         sticky_d = 1'b1;
    else if (ovf_clr) sticky_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      exc_q    <= exc_d;
      sticky_q <= sticky_d;
    end
  end

  assign ovf_exc    = exc_q;
  assign ovf_sticky = sticky_q;
endmodule

// File: rtl/alu_result_buffer.sv
// ALU output stage: 2-entry skid buffer with trap squash and a
// registered ready toward the ALU.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_r,
  input  logic             in_c_out,
  input  logic             in_v,
  input  logic [2:0]       in_aluop,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_trap_en,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_zero,
  output logic             out_carry,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf_exc,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);
  if (WIDTH != ALU_W || TAG_W != ALU_TAG_W) begin : g_chk
    $error("alu_result_buffer: widths must match alu_pkg");
  end

  alu_result_t main_q, main_d;
  alu_result_t skid_q, skid_d;
  alu_result_t in_e;
  logic main_v_q, main_v_d;
  logic skid_v_q, skid_v_d;
  logic rdy_q, rdy_d;
  logic fire, trap, store, drain;

  assign fire  = in_valid & rdy_q;
  assign store = fire & ~trap;
  assign drain = main_v_q & out_ready;

  always_comb begin
    in_e       = '0;
    in_e.r     = in_r;
    in_e.zero  = (in_r == '0);
    in_e.carry = in_c_out;
    in_e.tag   = in_tag;
  end

  alu_ovf_detect u_ovf (
    .clk       (clk),
    .reset     (reset),
    .in_fire   (fire),
    .in_v      (in_v),
    .in_aluop  (in_aluop),
    .in_trap_en(in_trap_en),
    .ovf_clr   (ovf_clr),
    .trap      (trap),
    .ovf_exc   (ovf_exc),
    .ovf_sticky(ovf_sticky)
  );

  // rdy_q == ~skid_v_q, so a store never coincides with a full skid.
  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (drain) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = store;
        if (store) main_d = in_e;
      end
    end else if (store) begin
      if (main_v_q) begin
        skid_d   = in_e;
        skid_v_d = 1'b1;
      end else begin
        main_d   = in_e;
        main_v_d = 1'b1;
      end
    end
    rdy_d = ~skid_v_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = main_v_q;
  assign out_r     = main_q.r;
  assign out_zero  = main_q.zero;
  assign out_carry = main_q.carry;
  assign out_tag   = main_q.tag;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: vector table for single ops,
// hand sequences for skid, trap/sticky, flush and async reset.
module tb_alu_result_buffer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_r;
  logic        in_c_out, in_v, in_trap_en;
  logic [2:0]  in_aluop;
  logic [4:0]  in_tag;
  logic        flush, out_valid, out_ready;
  logic [31:0] out_r;
  logic        out_zero, out_carry;
  logic [4:0]  out_tag;
  logic        ovf_exc, ovf_sticky, ovf_clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_result_buffer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_c_out(in_c_out), .in_v(in_v),
    .in_aluop(in_aluop), .in_tag(in_tag), .in_trap_en(in_trap_en),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_zero(out_zero), .out_carry(out_carry),
    .out_tag(out_tag), .ovf_exc(ovf_exc), .ovf_sticky(ovf_sticky),
    .ovf_clr(ovf_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] r;
    logic        c, v, en;
    logic [4:0]  tag;
    logic        e_valid, e_zero, e_exc;
  } vec_t;

  vec_t vt[8];

  task automatic drive(input logic [2:0] op, input logic [31:0] r,
                       input logic c, input logic v, input logic en,
                       input logic [4:0] tag);
    in_valid = 1'b1; in_aluop = op; in_r = r;
    in_c_out = c; in_v = v; in_trap_en = en; in_tag = tag;
  endtask

  initial begin
    vt[0] = '{ALU_ADD, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0};
    vt[1] = '{ALU_SUB, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 5'd7,  1'b1, 1'b1, 1'b0};
    vt[2] = '{ALU_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b1};
    vt[3] = '{ALU_OR,  32'h0000_F0F0, 1'b0, 1'b1, 1'b1, 5'd4,  1'b1, 1'b0, 1'b0};
    vt[4] = '{ALU_SUB, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0};
    vt[5] = '{ALU_SLT, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 5'd1,  1'b1, 1'b0, 1'b0};
    vt[6] = '{ALU_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 5'd2,  1'b0, 1'b0, 1'b1};
    vt[7] = '{ALU_AND, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_r = '0; in_c_out = 1'b0;
    in_v = 1'b0; in_aluop = ALU_AND; in_tag = '0; in_trap_en = 1'b0;
    flush = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_exc", {31'b0, ovf_exc}, 32'd0);
    chk("rst_sticky", {31'b0, ovf_sticky}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      drive(vt[i].op, vt[i].r, vt[i].c, vt[i].v, vt[i].en, vt[i].tag);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vt[i].e_valid});
      chk($sformatf("v%0d_exc", i), {31'b0, ovf_exc}, {31'b0, vt[i].e_exc});
      chk($sformatf("v%0d_ready", i), {31'b0, in_ready}, 32'd1);
      if (vt[i].e_valid) begin
        chk($sformatf("v%0d_r", i), out_r, vt[i].r);
        chk($sformatf("v%0d_zero", i), {31'b0, out_zero}, {31'b0, vt[i].e_zero});
        chk($sformatf("v%0d_carry", i), {31'b0, out_carry}, {31'b0, vt[i].c});
        chk($sformatf("v%0d_tag", i), {27'b0, out_tag}, {27'b0, vt[i].tag});
      end
      @(negedge clk);
      chk($sformatf("v%0d_drained", i), {31'b0, out_valid}, 32'd0);
      chk($sformatf("v%0d_exc_end", i), {31'b0, ovf_exc}, 32'd0);
    end
    chk("sticky_after_traps", {31'b0, ovf_sticky}, 32'd1);

    // sticky clear, then clear coinciding with a fresh trap
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("sticky_cleared", {31'b0, ovf_sticky}, 32'd0);
    ovf_clr = 1'b1;
    drive(ALU_ADD, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 5'd6);
    @(negedge clk);
    ovf_clr = 1'b0; in_valid = 1'b0;
    chk("clr_vs_trap_sticky", {31'b0, ovf_sticky}, 32'd1);
    chk("clr_vs_trap_exc", {31'b0, ovf_exc}, 32'd1);
    chk("clr_vs_trap_noout", {31'b0, out_valid}, 32'd0);

    // skid: A,B,C under stall, then drain in order
    out_ready = 1'b0;
    drive(ALU_ADD, 32'hAAAA_0001, 1'b0, 1'b0, 1'b1, 5'd10);
    @(negedge clk);
    chk("skA_valid", {31'b0, out_valid}, 32'd1);
    chk("skA_r", out_r, 32'hAAAA_0001);
    chk("skA_ready", {31'b0, in_ready}, 32'd1);
    drive(ALU_ADD, 32'hBBBB_0002, 1'b0, 1'b0, 1'b1, 5'd11);
    @(negedge clk);
    chk("skB_ready", {31'b0, in_ready}, 32'd0);
    chk("skB_main", out_r, 32'hAAAA_0001);
    drive(ALU_ADD, 32'hCCCC_0003, 1'b0, 1'b0, 1'b1, 5'd12);
    @(negedge clk);
    chk("skC_held_ready", {31'b0, in_ready}, 32'd0);
    chk("skC_held_main", out_r, 32'hAAAA_0001);
    out_ready = 1'b1;
    @(negedge clk);
    chk("dr1_r", out_r, 32'hBBBB_0002);
    chk("dr1_tag", {27'b0, out_tag}, 32'd11);
    chk("dr1_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("dr2_valid", {31'b0, out_valid}, 32'd1);
    chk("dr2_r", out_r, 32'hCCCC_0003);
    @(negedge clk);
    chk("dr3_empty", {31'b0, out_valid}, 32'd0);

    // flush with two entries and a concurrent request
    out_ready = 1'b0;
    drive(ALU_OR, 32'h0000_00D0, 1'b0, 1'b0, 1'b0, 5'd13);
    @(negedge clk);
    drive(ALU_OR, 32'h0000_00E0, 1'b0, 1'b0, 1'b0, 5'd14);
    @(negedge clk);
    chk("fl_full_ready", {31'b0, in_ready}, 32'd0);
    drive(ALU_OR, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 5'd15);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_ready", {31'b0, in_ready}, 32'd1);
    chk("fl_sticky", {31'b0, ovf_sticky}, 32'd1);

    // flush with an accepted trapping op: dropped but still traps
    drive(ALU_SUB, 32'h0, 1'b0, 1'b1, 1'b1, 5'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fltrap_exc", {31'b0, ovf_exc}, 32'd1);
    chk("fltrap_valid", {31'b0, out_valid}, 32'd0);

    // async reset mid-stall
    drive(ALU_ADD, 32'h0000_0077, 1'b0, 1'b0, 1'b1, 5'd3);
    @(negedge clk);
    drive(ALU_ADD, 32'h0000_0088, 1'b0, 1'b0, 1'b1, 5'd4);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_ready", {31'b0, in_ready}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_sticky", {31'b0, ovf_sticky}, 32'd0);
    chk("arst_exc", {31'b0, ovf_exc}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Registered output stage directly downstream of the 32-bit carry-lookahead ALU; captures ALU result, carry-out and overflow each time a valid operation completes.
- Derives a zero flag, detects signed-overflow traps on add/sub, and squashes trapping results.
- Forwards results to the memory/writeback stage over a valid/ready handshake.
- A 2-entry skid buffer holds results so a downstream stall never drops an ALU result; in_ready is purely registered.

Parameters:
- WIDTH, 32, datapath width of result.
- TAG_W, 5, width of destination-register tag carried alongside result.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  buffer can accept; registered.
- in_r  input  WIDTH  ALU result.
- in_c_out  input  1  ALU carry-out.
- in_v  input  1  ALU signed overflow.
- in_aluop  input  3  ALUop that produced the result.
- in_tag  input  TAG_W  destination register tag.
- in_trap_en  input  1  1 = signed op (add/sub overflow must trap).
- flush  input  1  discard all buffered entries.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts.
- out_r  output  WIDTH  buffered result.
- out_zero  output  1  out_r == 0.
- out_carry  output  1  buffered carry-out.
- out_tag  output  TAG_W  buffered tag.
- ovf_exc  output  1  one-cycle pulse on trapping overflow.
- ovf_sticky  output  1  sticky overflow status.
- ovf_clr  input  1  clears ovf_sticky.

Behaviour:
- Reset (async, active-high): main and skid entries invalid, all data regs 0, out_valid=0, in_ready=1, ovf_exc=0, ovf_sticky=0.
- Accept: in_valid & in_ready at rising edge. Latency 1 cycle: the accepted result appears on out_* the next cycle when the main entry is empty or drains that same cycle.
- Storage: main entry drives out_*; skid entry is filled only when accept occurs while main is valid and not draining (out_valid & ~out_ready).
- in_ready = ~skid_valid, registered. Upstream must hold in_valid/data stable while in_ready=0.
- Drain: out_valid & out_ready pops main; the skid entry moves to main in the same edge. Accept while draining: the incoming result goes to main if skid is empty, otherwise to skid.
- Order is strictly preserved; never more than 2 entries.
- out_zero is computed at capture from in_r (registered), not from out_r combinationally.
- Trap: accepted entry with in_trap_en=1, in_v=1 and in_aluop in {ADD, SUB}. The entry is not stored (squashed), ovf_exc=1 for exactly the next cycle, and ovf_sticky is set.
- in_v is ignored for AND/OR/SLT and when in_trap_en=0; that entry is stored normally.
- ovf_sticky: set wins over ovf_clr in the same cycle.
- flush: both entries are invalidated at the edge. An accept in the same cycle is also dropped, but still raises a trap if it qualifies. in_ready=1 the following cycle. ovf_sticky is unaffected.
- The data registers of invalid entries hold their previous values; out_* data are don't-care when out_valid=0.
- Reset mid-operation clears everything immediately, independent of clk.

Decomposition:
- Shared package alu_pkg holds:
  - ALUop constants: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111.
  - Default WIDTH=32.
  - A packed struct alu_result_t {r, zero, carry, tag}.
- One sub-module, alu_ovf_detect: combinational trap qualification plus ovf_exc/ovf_sticky registers. The skid storage stays in the top.

Test Plan:
- Reset, then one ADD result r=0x0000_0005, tag=3, out_ready=1 → out_valid=1 exactly one cycle later, out_r=5, out_zero=0, out_tag=3; in_ready stays 1.
- SUB result r=0, c_out=1 → out_zero=1, out_carry=1.
- Hold out_ready=0 and send 3 back-to-back results A,B,C → A in main, B in skid, in_ready=0 after B. C is held by upstream. Then out_ready=1 for 3 cycles → A,B,C delivered in order, with no loss or duplication.
- ADD with in_v=1, in_trap_en=1 → no out_valid, ovf_exc pulses 1 cycle, ovf_sticky=1. A later ovf_clr pulse → ovf_sticky=0. A simultaneous clr and new trap → ovf_sticky stays 1.
- OR with in_v=1, in_trap_en=1 → result forwarded normally, ovf_exc=0.
- Two entries buffered, then flush with a concurrent accept → out_valid=0 next cycle, in_ready=1. Assert reset asynchronously mid-stall → outputs return to reset values before the next clk edge.
